// File: rtl/tap_controller.sv
// tap_controller: IEEE 1149.1 TAP state machine with registered, glitch-free IR/DR control strobes.
module tap_controller (
  input  logic       clock,
  input  logic       reset,
  input  logic       tms,
  output logic [3:0] state,
  output logic       test_logic_reset,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       ir_clock_en,
  output logic       update_ir,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       dr_clock_en,
  output logic       update_dr,
  output logic       select_ir,
  output logic       tdo_enable
);
  typedef enum logic [3:0] {
    TLR  = 4'hF, RTI  = 4'hC,
    SDR  = 4'h7, CDR  = 4'h6, SHDR = 4'h2, E1DR = 4'h1, PDR = 4'h3, E2DR = 4'h0, UDR = 4'h5,
    SIR  = 4'h4, CIR  = 4'hE, SHIR = 4'hA, E1IR = 4'h9, PIR = 4'hB, E2IR = 4'h8, UIR = 4'hD
  } tap_state_e;
  tap_state_e cur, nxt;
  assign state = cur;
  always_comb begin
    nxt = TLR;
    unique case (cur)
      TLR:  nxt = tms ? TLR  : RTI;
      RTI:  nxt = tms ? SDR  : RTI;
      SDR:  nxt = tms ? SIR  : CDR;
      CDR:  nxt = tms ? E1DR : SHDR;
      SHDR: nxt = tms ? E1DR : SHDR;
      E1DR: nxt = tms ? UDR  : PDR;
      PDR:  nxt = tms ? E2DR : PDR;
      E2DR: nxt = tms ? UDR  : SHDR;
      UDR:  nxt = tms ? SDR  : RTI;
      SIR:  nxt = tms ? TLR  : CIR;
      CIR:  nxt = tms ? E1IR : SHIR;
      SHIR: nxt = tms ? E1IR : SHIR;
      E1IR: nxt = tms ? UIR  : PIR;
      PIR:  nxt = tms ? E2IR : PIR;
      E2IR: nxt = tms ? UIR  : SHIR;
      UIR:  nxt = tms ? SDR  : RTI;
    endcase
  end
  // Strobes are registered from the next-state decode so they change only on the clock edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur              <= TLR;
      test_logic_reset <= 1'b1;
      capture_ir       <= 1'b0;
      shift_ir         <= 1'b0;
      ir_clock_en      <= 1'b0;
      update_ir        <= 1'b0;
      capture_dr       <= 1'b0;
      shift_dr         <= 1'b0;
      dr_clock_en      <= 1'b0;
      update_dr        <= 1'b0;
      select_ir        <= 1'b0;
      tdo_enable       <= 1'b0;
    end else begin
      cur              <= nxt;
      test_logic_reset <= nxt == TLR;
      capture_ir       <= nxt == CIR;
      shift_ir         <= nxt == SHIR;
      ir_clock_en      <= nxt == CIR || nxt == SHIR;
      update_ir        <= nxt == UIR;
      capture_dr       <= nxt == CDR;
      shift_dr         <= nxt == SHDR;
      dr_clock_en      <= nxt == CDR || nxt == SHDR;
      update_dr        <= nxt == UDR;
      select_ir        <= nxt inside {SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR};
      tdo_enable       <= nxt == SHIR || nxt == SHDR;
    end
  end
endmodule

// File: tb/tb_tap_controller.sv
// tb_tap_controller: directed and random checks of tap_controller against a table-driven TAP model.
module tb_tap_controller;
  logic clock = 1'b0, reset = 1'b1, tms = 1'b0;
  logic [3:0] state;
  logic test_logic_reset, capture_ir, shift_ir, ir_clock_en, update_ir;
  logic capture_dr, shift_dr, dr_clock_en, update_dr, select_ir, tdo_enable;
  int total = 0, bad = 0;
  tap_controller dut (
    .clock(clock), .reset(reset), .tms(tms), .state(state),
    .test_logic_reset(test_logic_reset), .capture_ir(capture_ir), .shift_ir(shift_ir),
    .ir_clock_en(ir_clock_en), .update_ir(update_ir), .capture_dr(capture_dr),
    .shift_dr(shift_dr), .dr_clock_en(dr_clock_en), .update_dr(update_dr),
    .select_ir(select_ir), .tdo_enable(tdo_enable)
  );
  always #5 clock = ~clock;
  // Transition table by state code, transcribed from the standard's tms=0 / tms=1 columns.
  logic [3:0] n0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                          4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
  logic [3:0] n1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                          4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};
  logic [3:0] m;
  always @(posedge clock or posedge reset) m <= reset ? 4'hF : (tms ? n1[m] : n0[m]);
  function automatic logic [14:0] exp_vec(input logic [3:0] s);
    logic cir, shir, cdr, shdr;
    cir = s == 4'hE; shir = s == 4'hA; cdr = s == 4'h6; shdr = s == 4'h2;
    return {s, s == 4'hF, cir, shir, cir | shir, s == 4'hD, cdr, shdr, cdr | shdr,
            s == 4'h5, s inside {4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD}, shir | shdr};
  endfunction
  wire [14:0] dut_vec = {state, test_logic_reset, capture_ir, shift_ir, ir_clock_en, update_ir,
                         capture_dr, shift_dr, dr_clock_en, update_dr, select_ir, tdo_enable};
  wire [5:0] strobes = {capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr};
  task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clock) begin
    chk("model", dut_vec, exp_vec(m));
    chk("onehot", 15'($countones(strobes) <= 1), 15'd1);
  end
  task automatic step(input logic t);
    tms = t;
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #2 reset = 1'b0;
  endtask
  string ir_tms = "1100000110";
  logic [3:0] ir_exp [10] = '{4'h7, 4'h4, 4'hE, 4'hA, 4'hA, 4'hA, 4'hA, 4'h9, 4'hD, 4'hC};
  string dr_tms = "10001010110";
  logic [3:0] dr_exp [11] = '{4'h7, 4'h6, 4'h2, 4'h2, 4'h1, 4'h3, 4'h0, 4'h2, 4'h1, 4'h5, 4'hC};
  string paths [16] = '{"010101", "0101", "0100", "01010", "011", "01011", "010", "01",
                        "0110101", "01101", "01100", "011010", "0", "011011", "0110", ""};
  initial begin
    int c_ce, c_sh, c_up, c_sel, c_tdo;
    #12;
    chk("reset_vec", dut_vec, 15'h7C00);
    @(negedge clock);
    reset = 1'b0;
    step(1'b0);
    chk("rel_state", 15'(state), 15'hC);
    chk("rel_tlr", 15'(test_logic_reset), 15'd0);
    step(1'b0);
    chk("rti_hold", 15'(state), 15'hC);
    c_ce = 0; c_sh = 0; c_up = 0; c_sel = 0;
    for (int i = 0; i < 10; i++) begin
      step(ir_tms[i] == "1");
      chk($sformatf("ir_st%0d", i), 15'(state), 15'(ir_exp[i]));
      c_ce += int'(ir_clock_en); c_sh += int'(shift_ir); c_up += int'(update_ir); c_sel += int'(select_ir);
    end
    chk("ir_clock_en_cnt", 15'(c_ce), 15'd5);
    chk("shift_ir_cnt", 15'(c_sh), 15'd4);
    chk("update_ir_cnt", 15'(c_up), 15'd1);
    chk("select_ir_cnt", 15'(c_sel), 15'd8);
    c_sh = 0; c_up = 0; c_tdo = 0;
    for (int i = 0; i < 11; i++) begin
      step(dr_tms[i] == "1");
      chk($sformatf("dr_st%0d", i), 15'(state), 15'(dr_exp[i]));
      chk("tdo_eq_shdr", 15'(tdo_enable), 15'(shift_dr));
      c_sh += int'(shift_dr); c_up += int'(update_dr); c_tdo += int'(tdo_enable);
    end
    chk("shift_dr_cnt", 15'(c_sh), 15'd3);
    chk("update_dr_cnt", 15'(c_up), 15'd1);
    chk("tdo_cnt", 15'(c_tdo), 15'd3);
    for (int s = 0; s < 16; s++) begin
      do_reset();
      for (int k = 0; k < paths[s].len(); k++) step(paths[s][k] == "1");
      chk($sformatf("reach_%0h", s), 15'(state), 15'(s));
      c_up = 0;
      repeat (5) begin
        step(1'b1);
        c_up += int'(update_ir) + int'(update_dr);
      end
      chk($sformatf("tlr_from_%0h", s), 15'({state, test_logic_reset}), 15'h1F);
      chk($sformatf("upd_from_%0h", s), 15'(c_up <= 1), 15'd1);
    end
    do_reset();
    foreach (paths[10][k]) step(paths[10][k] == "1");
    step(1'b0);
    chk("pre_async_shir", 15'({shift_ir, ir_clock_en}), 15'b11);
    #2 reset = 1'b1;
    #1;
    chk("async_vec", dut_vec, 15'h7C00);
    @(negedge clock);
    reset = 1'b0;
    step(1'b0);
    chk("post_async", 15'(state), 15'hC);
    repeat (10000) step(1'($urandom_range(0, 1)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
